// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and the AES block-assembly controller.
// The receiver drives the byte and its status flags; the consumer returns rxRdyClr.
interface uart_rx_if;
  logic       rxRdyClr;
  logic       rxRdy;
  logic [0:7] dout;
  logic       frameErr;
  logic       overrun;

  modport master (
    input  rxRdyClr,
    output rxRdy,
    output dout,
    output frameErr,
    output overrun
  );

  modport slave (
    output rxRdyClr,
    input  rxRdy,
    input  dout,
    input  frameErr,
    input  overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; hands each byte to the AES block
// assembler through a level rxRdy / rxRdyClr handshake and flags framing errors and overruns.
module uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       sync_q;
  logic             rx_prev_q;
  logic             rx_s;
  logic             tick_s;
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       sc_q, sc_d;
  logic [2:0]       idx_q, idx_d;
  logic [0:7]       shreg_q, shreg_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             rdy_q, rdy_d;
  logic [0:7]       dout_q, dout_d;
  logic             ovr_q, ovr_d;

  assign rx_s   = sync_q[1];
  assign tick_s = (div_q == DIV_LAST);

  // Two-flop synchroniser plus the delayed copy used for start-edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
    end
  end

  // Frame sequencing: tick divider, sample counter, bit index and shift register
  always_comb begin
    state_d = state_q;
    div_d   = tick_s ? '0 : div_q + DIV_W'(1);
    sc_d    = sc_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a high-to-low transition starts a frame, so a line held low after a bad stop bit is ignored
        if (rx_prev_q && !rx_s) begin
          div_d   = '0;
          sc_d    = 4'd0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          if (sc_q == 4'd7) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              sc_d    = 4'd0;
              idx_d   = 3'd0;
              state_d = ST_DATA;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end else begin
          sc_d = sc_q;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (sc_q == 4'd15) begin
            shreg_d[3'd7 - idx_q] = rx_s;
            sc_d  = 4'd0;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d = ST_STOP;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end else begin
          sc_d = sc_q;
        end
      end
      ST_STOP: begin
        if (tick_s && (sc_q == 4'd15)) begin
          done_d  = rx_s;
          ferr_d  = ~rx_s;
          sc_d    = 4'd0;
          state_d = ST_IDLE;
        end else if (tick_s) begin
          sc_d = sc_q + 4'd1;
        end else begin
          sc_d = sc_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sc_d    = 4'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Frame-sequencing state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      sc_q    <= 4'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Consumer handshake: a completing byte wins over a simultaneous clear
  always_comb begin
    rdy_d  = rdy_q;
    dout_d = dout_q;
    ovr_d  = 1'b0;
    if (done_q) begin
      rdy_d  = 1'b1;
      dout_d = shreg_q;
      ovr_d  = rdy_q;
    end else if (bus.rxRdyClr) begin
      rdy_d = 1'b0;
    end else begin
      rdy_d = rdy_q;
    end
  end

  // Registered consumer-facing outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy_q  <= 1'b0;
      dout_q <= 8'h00;
      ovr_q  <= 1'b0;
    end else begin
      rdy_q  <= rdy_d;
      dout_q <= dout_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.rxRdy    = rdy_q;
  assign bus.dout     = dout_q;
  assign bus.frameErr = ferr_q;
  assign bus.overrun  = ovr_q;
endmodule
